// File: rtl/knn_voter.sv
// KNN majority voter: walks the sorter's K nearest ranks, reads each neighbour's label,
// tallies per-class votes and publishes the winning class with a one-cycle done pulse.
module knn_voter #(
  parameter int unsigned IDXW = 8,
  parameter int unsigned LBLW = 3,
  parameter int unsigned K    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IDXW-1:0] npts,
  input  logic [IDXW-1:0] idx,
  output logic [1:0]      sel,
  output logic            lbl_en,
  output logic [IDXW-1:0] lbl_addr,
  input  logic [LBLW-1:0] lbl_rdata,
  output logic            busy,
  output logic            done,
  output logic [LBLW-1:0] label
);

  localparam int unsigned NLBL = 2 ** LBLW;
  localparam int unsigned CW   = $clog2(K + 1);
  localparam logic [1:0]  RankLast = 2'(K - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StAcc   = 3'd2;
  localparam logic [2:0] StScan  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [1:0]      rank_q;
  logic [IDXW-1:0] addr_q;
  logic [CW-1:0]   cnt_q [NLBL];
  logic [LBLW-1:0] cls_q, best_q, label_q;
  logic [CW-1:0]   bestcnt_q;

  logic rank_last, cls_last, vote, better;

  assign rank_last = (rank_q == RankLast);
  assign cls_last  = (cls_q == {LBLW{1'b1}});
  // Ranks at or beyond npts were never filled by the sorter and must not vote.
  assign vote      = (IDXW'(rank_q) < npts);
  assign better    = (cnt_q[cls_q] > bestcnt_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: state_d = StAcc;
      StAcc:   state_d = rank_last ? StScan : StFetch;
      StScan:  if (cls_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rank_q    <= 2'd0;
      addr_q    <= '0;
      cls_q     <= '0;
      best_q    <= '0;
      bestcnt_q <= '0;
      label_q   <= '0;
      for (int i = 0; i < NLBL; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (start) begin
            rank_q <= 2'd0;
            for (int i = 0; i < NLBL; i++) cnt_q[i] <= '0;
          end
        end
        StFetch: addr_q <= idx;
        StAcc: begin
          if (vote) cnt_q[lbl_rdata] <= cnt_q[lbl_rdata] + CW'(1);
          if (rank_last) begin
            cls_q     <= '0;
            best_q    <= '0;
            bestcnt_q <= '0;
          end else begin
            rank_q <= rank_q + 2'd1;
          end
        end
        StScan: begin
          if (better) begin
            best_q    <= cls_q;
            bestcnt_q <= cnt_q[cls_q];
          end
          // Final winner is registered on the last scan step so label is valid alongside done.
          if (cls_last) label_q <= better ? cls_q : best_q;
          else          cls_q   <= cls_q + LBLW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sel      = rank_q;
  assign lbl_en   = (state_q == StFetch);
  assign lbl_addr = lbl_en ? idx : addr_q;
  assign busy     = (state_q == StFetch) || (state_q == StAcc) || (state_q == StScan);
  assign done     = (state_q == StDone);
  assign label    = label_q;

endmodule

// File: tb/tb_knn_voter.sv
// Self-checking bench for knn_voter: sorter/label-memory models plus a done/label scoreboard.
module tb_knn_voter;
  localparam int IDXW = 8;
  localparam int LBLW = 3;
  localparam int K    = 4;
  localparam int LAT  = 2 * K + (1 << LBLW) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [IDXW-1:0] npts = '0;
  logic [IDXW-1:0] idx;
  logic [1:0]      sel;
  logic            lbl_en;
  logic [IDXW-1:0] lbl_addr;
  logic [LBLW-1:0] lbl_rdata = '0;
  logic            busy, done;
  logic [LBLW-1:0] label;

  logic [IDXW-1:0] ranks [4];
  logic [LBLW-1:0] mem [256];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [LBLW-1:0] lbl;
    int              cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  knn_voter #(.IDXW(IDXW), .LBLW(LBLW), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .npts(npts), .idx(idx), .sel(sel),
    .lbl_en(lbl_en), .lbl_addr(lbl_addr), .lbl_rdata(lbl_rdata), .busy(busy),
    .done(done), .label(label)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (lbl_en) lbl_rdata <= mem[lbl_addr];
  assign idx = ranks[sel];

  // Scoreboard: every done must match the oldest pending expectation in label and cycle.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_done: got done at cycle %0d label %0d, required no done", cyc,
                 label);
      end else begin
        e = exp_q.pop_front();
        if (label !== e.lbl || cyc != e.cyc) begin
          n_errors++;
          $display("FAIL done_label: got label %0d at cycle %0d, required label %0d at cycle %0d",
                   label, cyc, e.lbl, e.cyc);
        end
      end
    end
  end

  function automatic logic [LBLW-1:0] model(input logic [LBLW-1:0] a, b, c, d, input int n);
    int cnt[8];
    logic [LBLW-1:0] l[4];
    logic [LBLW-1:0] best;
    int bc;
    l[0] = a; l[1] = b; l[2] = c; l[3] = d;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int r = 0; r < K; r++) if (r < n) cnt[l[r]]++;
    best = '0;
    bc = 0;
    for (int i = 0; i < 8; i++) if (cnt[i] > bc) begin best = LBLW'(i); bc = cnt[i]; end
    return best;
  endfunction

  task automatic set_case(input logic [IDXW-1:0] r0, r1, r2, r3,
                          input logic [LBLW-1:0] l0, l1, l2, l3, input logic [IDXW-1:0] n);
    ranks[0] = r0; ranks[1] = r1; ranks[2] = r2; ranks[3] = r3;
    mem[r0] = l0; mem[r1] = l1; mem[r2] = l2; mem[r3] = l3;
    npts = n;
  endtask

  // Called #1 after a posedge; start is high for 'hold' cycles beginning in the current one.
  task automatic launch(input logic [LBLW-1:0] exp_lbl, input int hold, output int s);
    start = 1'b1;
    s = cyc;
    exp_q.push_back('{lbl: exp_lbl, cyc: s + LAT});
    repeat (hold) begin @(posedge clk); #1; end
    start = 1'b0;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({sel, lbl_en, lbl_addr, busy, done, label} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got sel=%0d en=%0d addr=%0d busy=%0d done=%0d label=%0d, required all 0",
               sel, lbl_en, lbl_addr, busy, done, label);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic;
    int s, k;
    logic exp_en, exp_busy;
    set_case(8'd5, 8'd9, 8'd2, 8'd7, 3'd3, 3'd3, 3'd1, 3'd6, 8'd100);
    launch(3'd3, 1, s);
    while (cyc - s <= LAT) begin
      @(negedge clk);
      k = cyc - s;
      exp_busy = (k >= 1 && k <= LAT - 1);
      exp_en = (k == 1 || k == 3 || k == 5 || k == 7);
      n_checks++;
      if (busy !== exp_busy || lbl_en !== exp_en) begin
        n_errors++;
        $display("FAIL basic_busy_en: cycle %0d got busy=%0d en=%0d, required busy=%0d en=%0d",
                 k, busy, lbl_en, exp_busy, exp_en);
      end
      if (exp_en) begin
        n_checks++;
        if (lbl_addr !== ranks[(k - 1) / 2] || sel !== 2'((k - 1) / 2)) begin
          n_errors++;
          $display("FAIL basic_fetch: cycle %0d got addr=%0d sel=%0d, required addr=%0d sel=%0d",
                   k, lbl_addr, sel, ranks[(k - 1) / 2], (k - 1) / 2);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int s;
    set_case(8'd5, 8'd9, 8'd2, 8'd7, 3'd3, 3'd3, 3'd1, 3'd6, 8'd100);
    launch(3'd3, 1, s);
    wait_to(s + 3);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    n_checks++;
    if ({sel, lbl_en, lbl_addr, busy, done, label} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got sel=%0d en=%0d addr=%0d busy=%0d done=%0d label=%0d, required all 0",
               sel, lbl_en, lbl_addr, busy, done, label);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_ties;
    int s;
    set_case(8'd11, 8'd12, 8'd13, 8'd14, 3'd2, 3'd5, 3'd5, 3'd2, 8'd100);
    launch(3'd2, 1, s);
    wait_to(s + LAT + 1);
    set_case(8'd21, 8'd22, 8'd23, 8'd24, 3'd7, 3'd0, 3'd7, 3'd0, 8'd100);
    launch(3'd0, 1, s);
    wait_to(s + LAT + 1);
  endtask

  task automatic test_npts;
    int s;
    set_case(8'd31, 8'd32, 8'd33, 8'd34, 3'd4, 3'd1, 3'd1, 3'd1, 8'd2);
    launch(3'd1, 1, s);
    wait_to(s + LAT + 1);
    set_case(8'd41, 8'd42, 8'd43, 8'd44, 3'd5, 3'd5, 3'd5, 3'd5, 8'd0);
    launch(3'd0, 1, s);
    wait_to(s + LAT + 1);
  endtask

  task automatic test_back_to_back;
    int s, s2;
    set_case(8'd51, 8'd52, 8'd53, 8'd54, 3'd3, 3'd3, 3'd3, 3'd1, 8'd100);
    launch(3'd3, LAT + 1, s);  // start held through the whole run and its done cycle
    set_case(8'd61, 8'd62, 8'd63, 8'd64, 3'd6, 3'd6, 3'd6, 3'd6, 8'd100);
    launch(3'd6, 1, s2);
    n_checks++;
    if (s2 != s + LAT + 1) begin
      n_errors++;
      $display("FAIL b2b_start_cycle: got %0d, required %0d", s2, s + LAT + 1);
    end
    wait_to(s2 + LAT - 1);
    @(negedge clk);
    n_checks++;
    if (label !== 3'd3) begin
      n_errors++;
      $display("FAIL b2b_label_hold: got %0d, required 3", label);
    end
    @(posedge clk); #1;
    wait_to(s2 + LAT + 1);
  endtask

  task automatic test_midrun_reset;
    int s;
    set_case(8'd5, 8'd9, 8'd2, 8'd7, 3'd3, 3'd3, 3'd1, 3'd6, 8'd100);
    launch(3'd3, 1, s);
    wait_to(s + 6);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    n_checks++;
    if (label !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midrun_reset: got label=%0d done=%0d busy=%0d, required 0 0 0",
               label, done, busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    wait_to(s + LAT + 4);  // no done may appear from the aborted run
    launch(3'd3, 1, s);
    wait_to(s + LAT + 1);
  endtask

  task automatic test_random;
    int s;
    logic [LBLW-1:0] l[4];
    int n;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 4; i++) l[i] = LBLW'($urandom_range(0, 7));
      n = $urandom_range(0, 5);
      set_case(IDXW'(70 + $urandom_range(0, 9)), IDXW'(90 + $urandom_range(0, 9)),
               IDXW'(110 + $urandom_range(0, 9)), IDXW'(130 + $urandom_range(0, 9)),
               l[0], l[1], l[2], l[3], IDXW'(n));
      launch(model(l[0], l[1], l[2], l[3], n), 1, s);
      wait_to(s + LAT + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) ranks[i] = '0;
    test_reset();
    test_basic();
    test_async_reset();
    test_ties();
    test_npts();
    test_back_to_back();
    test_midrun_reset();
    test_random();
    wait_to(cyc + 4);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_done: got %0d pending expected dones, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
